in_service_control: RTL and testbench
=====================================

IN_SERVICE_CONTROL -- requirements
Module: in_service_control

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port INTFLAG  in  1  resolver reports an unmasked winning request.
REQ-004 SHALL have port PriorityID  in  3  index of winning request; valid while INTFLAG=1.
REQ-005 SHALL have port INTA_n  in  1  CPU acknowledge, active low; already synchronous to clk.
REQ-006 SHALL have port eoi_strobe  in  1  one-cycle pulse requesting an end-of-interrupt.
REQ-007 SHALL have port eoi_specific  in  1  1 = specific EOI on eoi_level; 0 = non-specific EOI.
REQ-008 SHALL have port eoi_level  in  3  target level for specific EOI.
REQ-009 SHALL have port eoi_rotate  in  1  1 = rotate priority on this EOI.
REQ-010 SHALL have port Rotating_priority  in  1  current priority mode; 1 = rotating.
REQ-011 SHALL have port aeoi_en  in  1  automatic EOI mode select.
REQ-012 SHALL have port vector_base  in  5  T7..T3 vector bits from ICW2.
REQ-013 SHALL have port INT  out  1  interrupt request to the CPU.
REQ-014 SHALL have port IS_status  out  8  in-service register.
REQ-015 SHALL have port last_serviced  out  3  lowest-priority level for rotation.
REQ-016 SHALL have port clear_irr  out  8  one-hot, one-cycle pulse that clears the IRR bit.
REQ-017 SHALL have port data_out  out  8  vector byte.
REQ-018 SHALL have port data_out_en  out  1  data_out valid; drives the bus enable.

Function
REQ-019 SHALL implement the FSM states IDLE, PEND, ACK1, GAP and ACK2.
REQ-020 SHALL detect INTA_n falling and rising edges against a registered copy of INTA_n, with 1-cycle latency.
REQ-021 IDLE: SHALL move to PEND with INT=1 on the cycle after INTFLAG=1.
REQ-022 PEND: on an INTA_n fall, SHALL latch PriorityID, set IS_status[id], pulse clear_irr[id], drop INT and enter ACK1.
REQ-023 PEND: if INTFLAG=0 at the INTA_n fall (spurious), SHALL latch id=7, leave IS_status and clear_irr unchanged, and set a spurious flag.
REQ-024 SHALL go ACK1→GAP on an INTA_n rise, then GAP→ACK2 on an INTA_n fall.
REQ-025 ACK2: SHALL drive data_out={vector_base,id} with data_out_en=1 until the INTA_n rise.
REQ-026 On the ACK2 INTA_n rise: if aeoi_en=1 and not spurious, SHALL clear IS_status[id]; SHALL then go to IDLE.
REQ-027 SHALL keep data_out_en=0 in every state except ACK2, and SHALL hold data_out at 0 whenever data_out_en=0.
REQ-028 SHALL ignore INTA_n edges in IDLE.
REQ-029 Non-specific EOI: SHALL clear the highest-priority set IS bit.
REQ-030 Non-specific EOI priority order: SHALL scan from level (last_serviced+1) mod 8 when Rotating_priority=1, else from level 0.
REQ-031 Non-specific EOI with IS_status=0: SHALL have no effect.
REQ-032 Specific EOI: SHALL clear IS_status[eoi_level]; clearing a bit already at 0 has no effect.
REQ-033 If eoi_rotate=1, SHALL load last_serviced with the cleared level; if no bit was cleared, last_serviced is unchanged.
REQ-034 If an EOI and an ISR set occur in the same cycle, SHALL resolve the EOI on the pre-set IS_status, then apply the set; set wins on the same bit.

Reset
REQ-035 While reset=1, SHALL force FSM=IDLE, INT=0, IS_status=0, last_serviced=7, clear_irr=0, data_out=0, data_out_en=0 and the spurious flag to 0.
REQ-036 Reset mid-acknowledge SHALL abandon the cycle without emitting any clear_irr pulse.

Configuration
REQ-037 With PIC_AEOI_EN defined, SHALL honour aeoi_en as described in REQ-026.
REQ-038 Without PIC_AEOI_EN, SHALL keep the aeoi_en port but ignore it, so that ISR bits clear only by EOI.

Structure
REQ-039 Package pic_pkg SHALL hold the FSM state enum, the IR7 spurious constant and the NUM_IR=8 constant.
REQ-040 SHALL contain a sub-module isr_priority_find: input a vector and a rotation base, output the index of the first set bit plus a found flag.

Verification
REQ-041 SHALL verify fixed order with INTFLAG=1, PriorityID=3, vector_base=5'h08 and two INTA pulses → clear_irr=8'h08, IS_status=8'h08, data_out=8'h43.
REQ-042 SHALL verify spurious acknowledge with INTFLAG dropped before the first INTA → data_out=8'h47 and IS_status unchanged.
REQ-043 SHALL verify rotating EOI with IS_status=8'h21, last_serviced=0, Rotating_priority=1 and a non-specific rotate EOI → bit 5 clears and last_serviced=5.
REQ-044 SHALL verify AEOI with aeoi_en=1 (macro defined) on id 2 → IS_status returns to 0 after the second INTA rise; without the macro it stays at 8'h04.
REQ-045 SHALL verify reset asserted in GAP → all outputs at reset values next cycle, and the next INTA is ignored.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt in-service control slice.
package pic_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam logic [2:0] IR_SPURIOUS = 3'd7;
    localparam logic [2:0] LAST_SERVICED_RST = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StPend,
        StAck1,
        StGap,
        StAck2
    } pic_state_e;

endpackage

// File: rtl/isr_priority_find.sv
// Finds the first set bit of vec_i, scanning upward (mod NUM_IR) from base_i.
module isr_priority_find
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] vec_i,
    input  logic [2:0]        base_i,
    output logic [2:0]        idx_o,
    output logic              found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Walk from the lowest priority back to the highest so the last hit wins.
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (vec_i[base_i + 3'(i)]) begin
                idx_o   = base_i + 3'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/in_service_control.sv
// INTA handshake sequencer, in-service register and EOI handling.
// Automatic EOI is only honoured when PIC_AEOI_EN is defined.
module in_service_control
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       INTFLAG,
    input  logic [2:0] PriorityID,
    input  logic       INTA_n,
    input  logic       eoi_strobe,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    input  logic       Rotating_priority,
    input  logic       aeoi_en,
    input  logic [4:0] vector_base,
    output logic       INT,
    output logic [7:0] IS_status,
    output logic [2:0] last_serviced,
    output logic [7:0] clear_irr,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    pic_state_e state_q;
    logic       inta_q;
    logic [2:0] id_q;
    logic       spurious_q;

    logic       inta_fall;
    logic       inta_rise;
    logic       aeoi_active;
    logic [2:0] scan_base;
    logic [2:0] pf_idx;
    logic       pf_found;
    logic [2:0] eoi_sel;
    logic       eoi_hit;
    logic [7:0] eoi_clr;
    logic [7:0] is_set;
    logic [7:0] is_aeoi;

    assign inta_fall = inta_q & ~INTA_n;
    assign inta_rise = ~inta_q & INTA_n;

`ifdef PIC_AEOI_EN
    assign aeoi_active = aeoi_en;
`else
    assign aeoi_active = aeoi_en & 1'b0;
`endif

    assign scan_base = Rotating_priority ? last_serviced + 3'd1 : 3'd0;

    isr_priority_find u_find (
        .vec_i   (IS_status),
        .base_i  (scan_base),
        .idx_o   (pf_idx),
        .found_o (pf_found)
    );

    // EOI resolves against the pre-set IS_status; a same-cycle set is OR-ed in afterwards.
    always_comb begin
        eoi_sel = eoi_specific ? eoi_level : pf_idx;
        eoi_hit = eoi_strobe & (eoi_specific ? IS_status[eoi_level] : pf_found);
        eoi_clr = eoi_hit ? (8'b1 << eoi_sel) : 8'b0;
        is_set  = 8'b0;
        is_aeoi = 8'b0;
        if (state_q == StPend && inta_fall && INTFLAG) begin
            is_set = 8'b1 << PriorityID;
        end
        if (state_q == StAck2 && inta_rise && aeoi_active && !spurious_q) begin
            is_aeoi = 8'b1 << id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            inta_q        <= 1'b1;
            id_q          <= '0;
            spurious_q    <= 1'b0;
            INT           <= 1'b0;
            IS_status     <= '0;
            last_serviced <= LAST_SERVICED_RST;
            clear_irr     <= '0;
            data_out      <= '0;
            data_out_en   <= 1'b0;
        end else begin
            inta_q    <= INTA_n;
            clear_irr <= is_set;
            IS_status <= (IS_status & ~eoi_clr & ~is_aeoi) | is_set;
            if (eoi_hit && eoi_rotate) begin
                last_serviced <= eoi_sel;
            end
            case (state_q)
                StIdle: begin
                    if (INTFLAG) begin
                        state_q <= StPend;
                        INT     <= 1'b1;
                    end
                end
                StPend: begin
                    if (inta_fall) begin
                        state_q    <= StAck1;
                        INT        <= 1'b0;
                        id_q       <= INTFLAG ? PriorityID : IR_SPURIOUS;
                        spurious_q <= ~INTFLAG;
                    end
                end
                StAck1: begin
                    if (inta_rise) begin
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (inta_fall) begin
                        state_q     <= StAck2;
                        data_out    <= {vector_base, id_q};
                        data_out_en <= 1'b1;
                    end
                end
                StAck2: begin
                    if (inta_rise) begin
                        state_q     <= StIdle;
                        data_out    <= '0;
                        data_out_en <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_in_service_control.sv
// Self-checking bench for in_service_control: directed cases then randomized traffic
// against a transaction-level model of the in-service register.
module tb_in_service_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       INTFLAG = 1'b0;
    logic [2:0] PriorityID = '0;
    logic       INTA_n = 1'b1;
    logic       eoi_strobe = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       eoi_rotate = 1'b0;
    logic       Rotating_priority = 1'b0;
    logic       aeoi_en = 1'b0;
    logic [4:0] vector_base = 5'h08;
    logic       INT;
    logic [7:0] IS_status;
    logic [2:0] last_serviced;
    logic [7:0] clear_irr;
    logic [7:0] data_out;
    logic       data_out_en;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_is = '0;
    logic [2:0] m_last = 3'd7;

    always #5 clk = ~clk;

    in_service_control dut (
        .clk               (clk),
        .reset             (reset),
        .INTFLAG           (INTFLAG),
        .PriorityID        (PriorityID),
        .INTA_n            (INTA_n),
        .eoi_strobe        (eoi_strobe),
        .eoi_specific      (eoi_specific),
        .eoi_level         (eoi_level),
        .eoi_rotate        (eoi_rotate),
        .Rotating_priority (Rotating_priority),
        .aeoi_en           (aeoi_en),
        .vector_base       (vector_base),
        .INT               (INT),
        .IS_status         (IS_status),
        .last_serviced     (last_serviced),
        .clear_irr         (clear_irr),
        .data_out          (data_out),
        .data_out_en       (data_out_en)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clears the level an EOI targets: specific level, or first set bit in priority order.
    task automatic model_eoi(input bit spec, input logic [2:0] lvl, input bit rot, input bit rmode);
        int hit;
        int start;
        hit = -1;
        start = rmode ? (int'(m_last) + 1) % 8 : 0;
        if (spec) begin
            if (m_is[lvl]) hit = int'(lvl);
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (hit < 0 && m_is[(start + k) % 8]) hit = (start + k) % 8;
            end
        end
        if (hit >= 0) begin
            m_is[hit] = 1'b0;
            if (rot) m_last = 3'(hit);
        end
    endtask

    task automatic drive_eoi(input bit spec, input logic [2:0] lvl, input bit rot, input bit rmode);
        eoi_strobe        = 1'b1;
        eoi_specific      = spec;
        eoi_level         = lvl;
        eoi_rotate        = rot;
        Rotating_priority = rmode;
    endtask

    task automatic do_eoi(input bit spec, input logic [2:0] lvl, input bit rot, input bit rmode);
        drive_eoi(spec, lvl, rot, rmode);
        tick;
        eoi_strobe = 1'b0;
        model_eoi(spec, lvl, rot, rmode);
        chk("eoi_is", IS_status, m_is);
        chk("eoi_last", last_serviced, m_last);
    endtask

    // Full two-pulse acknowledge; optional EOI lands in the same cycle as the ISR set.
    task automatic do_ack(input bit spur, input logic [2:0] id, input bit aeoi, input bit ev,
                          input bit es, input logic [2:0] el, input bit er, input bit rm);
        logic [2:0] lid;
        logic [7:0] exp_clr;
        lid     = spur ? 3'd7 : id;
        exp_clr = spur ? 8'h00 : (8'b1 << id);
        INTFLAG    = 1'b1;
        PriorityID = id;
        aeoi_en    = aeoi;
        tick;
        chk("pend_int", INT, 1);
        chk("pend_en", data_out_en, 0);
        INTA_n = 1'b0;
        if (spur) INTFLAG = 1'b0;
        if (ev) drive_eoi(es, el, er, rm);
        tick;
        eoi_strobe = 1'b0;
        INTFLAG    = 1'b0;
        if (ev) model_eoi(es, el, er, rm);
        if (!spur) m_is[id] = 1'b1;
        chk("ack1_clear_irr", clear_irr, exp_clr);
        chk("ack1_is", IS_status, m_is);
        chk("ack1_last", last_serviced, m_last);
        chk("ack1_int", INT, 0);
        chk("ack1_en", data_out_en, 0);
        tick;
        chk("clear_irr_one_cycle", clear_irr, 0);
        INTA_n = 1'b1;
        tick;
        chk("gap_en", data_out_en, 0);
        chk("gap_dout", data_out, 0);
        INTA_n = 1'b0;
        tick;
        chk("ack2_en", data_out_en, 1);
        chk("ack2_dout", data_out, {vector_base, lid});
        tick;
        chk("ack2_hold", data_out, {vector_base, lid});
        INTA_n = 1'b1;
        tick;
`ifdef PIC_AEOI_EN
        if (aeoi && !spur) m_is[lid] = 1'b0;
`endif
        chk("idle_en", data_out_en, 0);
        chk("idle_dout", data_out, 0);
        chk("idle_is", IS_status, m_is);
        aeoi_en = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_int", INT, 0);
        chk("rst_is", IS_status, 8'h00);
        chk("rst_last", last_serviced, 3'd7);
        chk("rst_clear_irr", clear_irr, 8'h00);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_en", data_out_en, 0);
        reset = 1'b0;
        tick;

        // Fixed order, id 3, vector base 0x08.
        vector_base = 5'h08;
        do_ack(0, 3'd3, 0, 0, 0, 3'd0, 0, 0);
        chk("fixed_vector", {vector_base, 3'd3}, 8'h43);
        chk("fixed_is", IS_status, 8'h08);

        // Spurious: INTFLAG gone at the first INTA fall.
        do_ack(1, 3'd2, 0, 0, 0, 3'd0, 0, 0);
        chk("spur_is", IS_status, 8'h08);
        do_eoi(1, 3'd3, 0, 0);

        // Rotating non-specific EOI from IS=0x21 with last_serviced=0.
        do_ack(0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        do_eoi(1, 3'd0, 1, 0);
        chk("rot_last0", last_serviced, 3'd0);
        do_ack(0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        do_ack(0, 3'd5, 0, 0, 0, 3'd0, 0, 0);
        chk("rot_pre_is", IS_status, 8'h21);
        do_eoi(0, 3'd0, 1, 1);
        chk("rot_is", IS_status, 8'h01);
        chk("rot_last", last_serviced, 3'd5);
        do_eoi(0, 3'd0, 0, 0);
        do_eoi(0, 3'd0, 1, 0);
        chk("eoi_empty_last", last_serviced, 3'd5);

        // Automatic EOI on id 2.
        do_ack(0, 3'd2, 1, 0, 0, 3'd0, 0, 0);
`ifdef PIC_AEOI_EN
        chk("aeoi_is", IS_status, 8'h00);
`else
        chk("aeoi_is", IS_status, 8'h04);
`endif

        // EOI and set on the same bit in the same cycle: the set survives.
        do_ack(0, 3'd2, 0, 1, 1, 3'd2, 1, 0);
        chk("same_cycle_is", IS_status[2], 1);

        // Reset while in GAP, then a stray INTA pulse.
        INTFLAG    = 1'b1;
        PriorityID = 3'd1;
        tick;
        INTA_n = 1'b0;
        tick;
        INTFLAG = 1'b0;
        INTA_n  = 1'b1;
        tick;
        reset = 1'b1;
        tick;
        m_is   = '0;
        m_last = 3'd7;
        chk("gaprst_int", INT, 0);
        chk("gaprst_is", IS_status, 8'h00);
        chk("gaprst_last", last_serviced, 3'd7);
        chk("gaprst_clear_irr", clear_irr, 8'h00);
        chk("gaprst_en", data_out_en, 0);
        chk("gaprst_dout", data_out, 8'h00);
        reset  = 1'b0;
        INTA_n = 1'b0;
        tick;
        tick;
        chk("stray_en", data_out_en, 0);
        chk("stray_clear_irr", clear_irr, 8'h00);
        chk("stray_int", INT, 0);
        INTA_n = 1'b1;
        tick;
        tick;
        chk("stray_rise_en", data_out_en, 0);
        chk("stray_is", IS_status, 8'h00);

        // Randomized mix of acknowledges and EOIs.
        for (int n = 0; n < 60; n++) begin
            vector_base = 5'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                do_eoi(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                do_ack($urandom_range(0, 7) == 0, 3'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, 1'($urandom), 3'($urandom),
                       1'($urandom), 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
